// File: rtl/dmem_pkg.sv
// Shared constants and the write-buffer entry type for the data-memory responder.
package dmem_pkg;

    localparam int DATA_W             = 32;
    localparam int DEF_ADDR_WIDTH     = 6;
    localparam int DEF_WB_DEPTH       = 4;
    localparam int DEF_DRAIN_INTERVAL = 2;

    // Widest word index a 32-bit byte address can carry; narrower arrays zero-extend.
    localparam int IDX_W = 30;

    typedef struct packed {
        logic [IDX_W-1:0]  index;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Posted-store write buffer: circular entry storage with a separate occupancy count
// and a parallel youngest-match lookup used for read-after-write forwarding.
module wbuf_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEF_WB_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_i,
    input  wb_entry_t               push_entry_i,
    input  logic                    pop_i,
    output wb_entry_t               head_o,
    input  logic [IDX_W-1:0]        lookup_idx_i,
    output logic                    hit_o,
    output logic [DATA_W-1:0]       hit_data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
        else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
    end

    // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: entry storage is deliberately not reset; the pointers and count alone define which slots are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_entry_i;
    end

    // Walk oldest to youngest so the last valid match wins.
    always_comb begin
        logic [PTR_W-1:0] slot;
        slot       = rd_ptr_q;
        hit_o      = 1'b0;
        hit_data_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (mem_q[slot].index == lookup_idx_i)) begin
                hit_o      = 1'b1;
                hit_data_o = mem_q[slot].data;
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// M-stage data-memory responder: posted stores drain from a write buffer into a slower
// word array; loads forward from the buffer. Optional overflow checking: DMEM_OVF_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int WB_DEPTH       = DEF_WB_DEPTH,
    parameter int DRAIN_INTERVAL = DEF_DRAIN_INTERVAL
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       MemWriteM,
    input  logic [31:0]                ALUResult,
    input  logic [31:0]                WriteData,
    output logic [31:0]                ReadData,
    output logic                       WbFull,
    output logic                       WbEmpty,
    output logic [$clog2(WB_DEPTH):0]  WbCount,
    output logic                       WbOverflow
);

    localparam int DRAIN_W = (DRAIN_INTERVAL > 1) ? $clog2(DRAIN_INTERVAL) : 1;

    logic [DATA_W-1:0]     mem_q [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [DRAIN_W-1:0]    drain_cnt_q, drain_cnt_d;
    logic                  drain_last;
    logic                  pop;
    wb_entry_t             push_entry;
    wb_entry_t             head;
    logic                  hit;
    logic [DATA_W-1:0]     hit_data;
    logic                  unused_bits;

    assign word_idx   = ALUResult[ADDR_WIDTH+1:2];
    assign push_entry = '{index: IDX_W'(word_idx), data: WriteData};
    assign drain_last = (drain_cnt_q == DRAIN_W'(DRAIN_INTERVAL - 1));
    assign pop        = drain_last && !WbEmpty;

    wbuf_fifo #(
        .DEPTH (WB_DEPTH)
    ) u_wbuf (
        .clk          (clk),
        .reset        (reset),
        .push_i       (MemWriteM),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .lookup_idx_i (IDX_W'(word_idx)),
        .hit_o        (hit),
        .hit_data_o   (hit_data),
        .full_o       (WbFull),
        .empty_o      (WbEmpty),
        .count_o      (WbCount)
    );

    always_comb begin
        drain_cnt_d = drain_last ? '0 : drain_cnt_q + DRAIN_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) drain_cnt_q <= '0;
        else       drain_cnt_q <= drain_cnt_d;
    end

    // A reset edge discards pending entries, so it must also suppress the drain write.
    always_ff @(posedge clk) begin
        if (pop && !reset) mem_q[head.index[ADDR_WIDTH-1:0]] <= head.data;
    end

    assign ReadData = hit ? hit_data : mem_q[word_idx];

    assign unused_bits = ^{ALUResult[31:ADDR_WIDTH+2], ALUResult[1:0],
                           head.index[IDX_W-1:ADDR_WIDTH]};

`ifdef DMEM_OVF_CHECK_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (MemWriteM && WbFull) begin
            ovf_q <= 1'b1;
            $display("dmem_responder warning: store to word index %0d dropped, write buffer full",
                     word_idx);
        end
    end

    assign WbOverflow = ovf_q;
`else
    assign WbOverflow = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver queues expected outputs, a negedge monitor compares.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        WbFull;
    logic        WbEmpty;
    logic [2:0]  WbCount;
    logic        WbOverflow;

`ifdef DMEM_OVF_CHECK_EN
    localparam logic [31:0] OVF_EXP = 32'd1;
`else
    localparam logic [31:0] OVF_EXP = 32'd0;
`endif

    localparam logic [31:0] X0 = 32'h1111_0000, X1 = 32'h2222_1111;
    localparam logic [31:0] X2 = 32'h3333_2222, X3 = 32'h4444_3333;
    localparam logic [31:0] C0 = 32'hC0C0_0000, C1 = 32'hC1C1_1111, C2 = 32'hC2C2_2222;

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_WIDTH     (6),
        .WB_DEPTH       (4),
        .DRAIN_INTERVAL (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .ALUResult  (ALUResult),
        .WriteData  (WriteData),
        .ReadData   (ReadData),
        .WbFull     (WbFull),
        .WbEmpty    (WbEmpty),
        .WbCount    (WbCount),
        .WbOverflow (WbOverflow)
    );

    typedef enum {SEL_RD, SEL_CNT, SEL_FULL, SEL_EMPTY, SEL_OVF} sel_t;
    typedef struct {
        string       name;
        sel_t        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] mon_act;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string name, input sel_t sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        MemWriteM = 1'b1;
        ALUResult = addr;
        WriteData = data;
        step();
        MemWriteM = 1'b0;
    endtask

    task automatic do_reset();
        MemWriteM = 1'b0;
        reset     = 1'b1;
        step();
        step();
        reset     = 1'b0;
    endtask

    // Monitor: samples mid-cycle and consumes every expectation queued for this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            case (mon_e.sel)
                SEL_RD:    mon_act = ReadData;
                SEL_CNT:   mon_act = 32'(WbCount);
                SEL_FULL:  mon_act = 32'(WbFull);
                SEL_EMPTY: mon_act = 32'(WbEmpty);
                default:   mon_act = 32'(WbOverflow);
            endcase
            check(mon_e.name, mon_act, mon_e.exp);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        MemWriteM = 1'b0;
        ALUResult = '0;
        WriteData = '0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        expect_out("rst_empty", SEL_EMPTY, 1);
        expect_out("rst_count", SEL_CNT,   0);
        expect_out("rst_full",  SEL_FULL,  0);
        expect_out("rst_ovf",   SEL_OVF,   0);

        // Single store, forwarded next cycle, then served from the array
        store(32'h10, 32'hDEAD_BEEF);
        ALUResult = 32'h10;
        expect_out("single_fwd_rd",  SEL_RD,  32'hDEAD_BEEF);
        expect_out("single_fwd_cnt", SEL_CNT, 1);
        step();
        step();
        expect_out("single_empty",    SEL_EMPTY, 1);
        expect_out("single_array_rd", SEL_RD,    32'hDEAD_BEEF);
        step();

        // Youngest of three same-address stores wins
        do_reset();
        store(32'h20, 32'h1);
        store(32'h20, 32'h2);
        store(32'h20, 32'h3);
        ALUResult = 32'h20;
        expect_out("young_fwd_rd", SEL_RD,  32'h3);
        expect_out("young_cnt",    SEL_CNT, 2);
        step();
        step();
        step();
        expect_out("young_empty",    SEL_EMPTY, 1);
        expect_out("young_array_rd", SEL_RD,    32'h3);
        step();

        // Push and pop on the same edge keep the count at 2
        do_reset();
        store(32'h30, X0);
        store(32'h34, X1);
        store(32'h38, X2);
        expect_out("pp_cnt_before", SEL_CNT, 2);
        store(32'h3C, X3);
        expect_out("pp_cnt_after", SEL_CNT, 2);
        ALUResult = 32'h38;
        expect_out("pp_fwd_x2", SEL_RD, X2);
        step();
        ALUResult = 32'h34;
        expect_out("pp_array_x1", SEL_RD, X1);
        step();
        ALUResult = 32'h3C;
        expect_out("pp_fwd_x3",  SEL_RD,  X3);
        expect_out("pp_cnt_mid", SEL_CNT, 1);
        step();
        step();
        expect_out("pp_empty",    SEL_EMPTY, 1);
        expect_out("pp_array_x3", SEL_RD,    X3);
        step();

        // Back-to-back stores fill the buffer despite drains; a store while full is dropped
        do_reset();
        for (int i = 0; i < 7; i++) store(32'h40 + 32'(4 * i), 32'hA0 + 32'(i));
        expect_out("fill_full",  SEL_FULL,  1);
        expect_out("fill_cnt",   SEL_CNT,   4);
        expect_out("fill_empty", SEL_EMPTY, 0);
        store(32'h10, 32'h0000_0BAD);
        expect_out("drop_cnt",  SEL_CNT,  3);
        expect_out("drop_full", SEL_FULL, 0);
        expect_out("drop_ovf",  SEL_OVF,  OVF_EXP);
        ALUResult = 32'h10;
        expect_out("drop_rd_old", SEL_RD, 32'hDEAD_BEEF);
        step();
        ALUResult = 32'hFFFF_FF5B;
        expect_out("fill_fwd_a6_hibits", SEL_RD, 32'hA6);
        step();
        ALUResult = 32'h4C;
        expect_out("fill_array_a3", SEL_RD, 32'hA3);
        step();
        step();
        step();
        step();
        ALUResult = 32'h58;
        expect_out("fill_drained",    SEL_EMPTY, 1);
        expect_out("fill_ovf_sticky", SEL_OVF,   OVF_EXP);
        expect_out("fill_array_a6",   SEL_RD,    32'hA6);
        step();

        // Reset with entries pending discards them before they reach the array
        do_reset();
        expect_out("mid_ovf_clear", SEL_OVF, 0);
        store(32'h30, C0);
        store(32'h34, C1);
        store(32'h38, C2);
        expect_out("mid_cnt_pending", SEL_CNT, 2);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        expect_out("mid_rst_cnt",   SEL_CNT,   0);
        expect_out("mid_rst_empty", SEL_EMPTY, 1);
        ALUResult = 32'h34;
        expect_out("mid_old_x1", SEL_RD, X1);
        step();
        ALUResult = 32'h38;
        expect_out("mid_old_x2", SEL_RD, X2);
        step();
        ALUResult = 32'h30;
        expect_out("mid_drained_c0", SEL_RD, C0);
        step();

        for (int i = 0; i < 10 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left unchecked, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
